// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } avalon_resp_state_t;

  localparam int         BYTE_LANES = 4;
  // Fibonacci taps 8,6,5,4 expressed as register bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  function automatic logic [1:0] lfsr_stall(input logic [7:0] value);
    return 2'(value & 8'h03);
  endfunction

endpackage

// File: rtl/mips_avalon_mem_responder_if.sv
// Avalon-MM bus bundle between the mips_cpu_bus master and the memory responder.
interface mips_avalon_mem_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        error;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, error
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, error
  );
endinterface

// File: rtl/mips_avalon_stall_lfsr.sv
// 8-bit Fibonacci LFSR supplying pseudo-random extra wait states; steps once per accepted access.
module mips_avalon_stall_lfsr
  import mips_avalon_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= seed;
    end else if (advance) begin
      r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  assign value = r_lfsr;

endmodule

// File: rtl/mips_avalon_mem_responder.sv
// Avalon-MM slave word memory with fixed and pseudo-random wait states, byte-lane writes,
// address range checking and a sticky error flag.
module mips_avalon_mem_responder
  import mips_avalon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hBFC0_0000,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter bit          RANDOM_STALL = 1'b0,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  mips_avalon_mem_responder_if.slave   s_av
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  avalon_resp_state_t r_state, w_state_nxt;
  logic [31:0]        r_count, w_count_nxt;
  logic               r_error;
  logic [31:0]        r_mem [DEPTH];

  logic               w_req;
  logic               w_wait;
  logic               w_access;
  logic               w_access_en;
  logic               w_do_write;
  logic [7:0]         w_lfsr;
  logic [31:0]        w_total_wait;
  logic [31:0]        w_offset;
  logic               w_in_range;
  logic [IDX_W-1:0]   w_idx;

  mips_avalon_stall_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (w_access_en),
    .seed    (LFSR_SEED),
    .value   (w_lfsr)
  );

  assign w_req        = s_av.read | s_av.write;
  assign w_total_wait = WAIT_CYCLES + (RANDOM_STALL ? 32'(lfsr_stall(w_lfsr)) : 32'd0);

  // Range check on the full 32-bit offset; only then is it truncated to a word index.
  assign w_offset   = s_av.address - BASE_ADDR;
  assign w_in_range = (s_av.address >= BASE_ADDR) && (w_offset < SPAN);
  assign w_idx      = w_offset[IDX_W+1:2];

  // The IDLE cycle of a request is itself the first wait state, so WAIT holds total_wait-1 more.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_wait      = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_total_wait == 32'd0) begin
            w_access = 1'b1;
          end else begin
            w_wait = 1'b1;
            if (w_total_wait == 32'd1) begin
              w_state_nxt = ACCESS;
            end else begin
              w_state_nxt = WAIT;
              w_count_nxt = w_total_wait - 32'd2;
            end
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else begin
          w_wait = 1'b1;
          if (r_count == 32'd0) begin
            w_state_nxt = ACCESS;
          end else begin
            w_count_nxt = r_count - 32'd1;
          end
        end
      end
      ACCESS: begin
        w_access    = w_req;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_access_en = w_access & reset;
  assign w_do_write  = w_access_en & s_av.write & ~s_av.read & w_in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= 32'd0;
      r_error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_access_en && (!w_in_range || (s_av.read && s_av.write))) begin
        r_error <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (s_av.byteenable[i]) begin
          r_mem[w_idx][8*i +: 8] <= s_av.writedata[8*i +: 8];
        end
      end
    end
  end

  assign s_av.waitrequest = w_wait & reset;
  assign s_av.readdata    = (w_access_en && s_av.read && w_in_range) ? r_mem[w_idx] : 32'h0;
  assign s_av.error       = r_error;

endmodule

// File: tb/tb_mips_avalon_mem_responder.sv
// Directed bench driving four responder configurations through one shared master port.
module tb_mips_avalon_mem_responder;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  m_sel;
  logic [31:0] m_addr, m_wdata;
  logic        m_read, m_write;
  logic [3:0]  m_be;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  lfsr_m;
  bit          exp_err [4];
  logic [31:0] mdl [int];
  exp_t        sb [$];

  mips_avalon_mem_responder_if av0 ();
  mips_avalon_mem_responder_if av1 ();
  mips_avalon_mem_responder_if av2 ();
  mips_avalon_mem_responder_if av3 ();

  assign av0.address = m_addr; assign av0.byteenable = m_be; assign av0.writedata = m_wdata;
  assign av1.address = m_addr; assign av1.byteenable = m_be; assign av1.writedata = m_wdata;
  assign av2.address = m_addr; assign av2.byteenable = m_be; assign av2.writedata = m_wdata;
  assign av3.address = m_addr; assign av3.byteenable = m_be; assign av3.writedata = m_wdata;
  assign av0.read = m_read && (m_sel == 2'd0); assign av0.write = m_write && (m_sel == 2'd0);
  assign av1.read = m_read && (m_sel == 2'd1); assign av1.write = m_write && (m_sel == 2'd1);
  assign av2.read = m_read && (m_sel == 2'd2); assign av2.write = m_write && (m_sel == 2'd2);
  assign av3.read = m_read && (m_sel == 2'd3); assign av3.write = m_write && (m_sel == 2'd3);

  mips_avalon_mem_responder #(.BASE_ADDR(BASE), .DEPTH(1024), .WAIT_CYCLES(0),
    .RANDOM_STALL(1'b0), .LFSR_SEED(8'hA5)) u0 (.clk(clk), .reset(reset), .s_av(av0));
  mips_avalon_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_CYCLES(2),
    .RANDOM_STALL(1'b0), .LFSR_SEED(8'hA5)) u1 (.clk(clk), .reset(reset), .s_av(av1));
  mips_avalon_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_CYCLES(3),
    .RANDOM_STALL(1'b0), .LFSR_SEED(8'hA5)) u2 (.clk(clk), .reset(reset), .s_av(av2));
  mips_avalon_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_CYCLES(0),
    .RANDOM_STALL(1'b1), .LFSR_SEED(8'hA5)) u3 (.clk(clk), .reset(reset), .s_av(av3));

  logic        w_wait;
  logic [31:0] w_rdata;
  logic [3:0]  w_err;

  always_comb begin
    w_wait  = av0.waitrequest;
    w_rdata = av0.readdata;
    case (m_sel)
      2'd1:    begin w_wait = av1.waitrequest; w_rdata = av1.readdata; end
      2'd2:    begin w_wait = av2.waitrequest; w_rdata = av2.readdata; end
      2'd3:    begin w_wait = av3.waitrequest; w_rdata = av3.readdata; end
      default: begin w_wait = av0.waitrequest; w_rdata = av0.readdata; end
    endcase
  end
  assign w_err = {av3.error, av2.error, av1.error, av0.error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input int s);
    return (s == 0) ? 1024 : 64;
  endfunction

  function automatic bit in_rng(input int s, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && (off < 32'(4 * depth_of(s)));
  endfunction

  function automatic int key_of(input int s, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (s << 16) | int'(off[15:2]);
  endfunction

  function automatic int stall_of(input int s);
    case (s)
      1:       return 2;
      2:       return 3;
      3:       return int'(lfsr_m[1:0]);
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] err_vec();
    return {exp_err[3], exp_err[2], exp_err[1], exp_err[0]};
  endfunction

  // Called just after a rising edge; returns just after the edge that completes the access.
  task automatic xfer(input int s, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input bit keep, input string tag);
    exp_t        e, got;
    int          n;
    bit          done, ok;
    int          k;
    logic [31:0] rdata, cur;
    n     = 0;
    done  = 1'b0;
    rdata = 32'h0;
    ok    = in_rng(s, a);
    k     = key_of(s, a);
    e.stall = stall_of(s);
    e.data  = (rd && ok && mdl.exists(k)) ? mdl[k] : 32'h0;
    sb.push_back(e);
    m_sel = 2'(s); m_addr = a; m_read = rd; m_write = wr; m_be = be; m_wdata = wd;
    while (!done && n < 64) begin
      @(negedge clk);
      if (w_wait === 1'b0) begin
        done  = 1'b1;
        rdata = w_rdata;
      end else begin
        n++;
        check({tag, " rdata while stalled"}, w_rdata, 32'h0);
      end
      @(posedge clk); #1;
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    if (done) begin
      if (wr && !rd && ok) begin
        cur = mdl.exists(k) ? mdl[k] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
        mdl[k] = cur;
      end
      if (!ok || (rd && wr)) exp_err[s] = 1'b1;
      if (s == 3) lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
    if (!keep) begin m_read = 1'b0; m_write = 1'b0; end
    got = sb.pop_front();
    check({tag, " stall cycles"}, 32'(n), 32'(got.stall));
    check({tag, " readdata"}, rdata, got.data);
    check({tag, " error"}, 32'(w_err[s]), 32'(exp_err[s]));
  endtask

  initial begin
    reset = 1'b1; m_sel = 2'd1; m_addr = BASE + 32'd4; m_read = 1'b0; m_write = 1'b0;
    m_be = 4'h0; m_wdata = 32'h0; lfsr_m = 8'hA5;
    for (int i = 0; i < 4; i++) exp_err[i] = 1'b0;
    #1 reset = 1'b0;
    m_read = 1'b1;
    @(negedge clk);
    check("reset waitrequest", 32'(w_wait), 32'd0);
    check("reset readdata", w_rdata, 32'h0);
    check("reset error", 32'(w_err), 32'h0);
    m_read = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    m_sel = 2'd0;
    @(negedge clk);
    check("idle waitrequest", 32'(w_wait), 32'd0);
    @(posedge clk); #1;

    // Zero-wait write then read, partial byte-lane merge, empty byteenable.
    xfer(0, 1'b0, 1'b1, BASE,         4'hF,    32'hDEAD_BEEF, 1'b0, "t1 wr");
    xfer(0, 1'b1, 1'b0, BASE,         4'hF,    32'h0,         1'b0, "t1 rd");
    xfer(0, 1'b0, 1'b1, BASE + 32'd8, 4'hF,    32'h1122_3344, 1'b0, "t3 preload");
    xfer(0, 1'b0, 1'b1, BASE + 32'd8, 4'b0101, 32'hAABB_CCDD, 1'b0, "t3 merge");
    xfer(0, 1'b1, 1'b0, BASE + 32'd8, 4'hF,    32'h0,         1'b0, "t3 rd");
    check("t3 merged constant", mdl[key_of(0, BASE + 32'd8)], 32'h11BB_33DD);
    xfer(0, 1'b0, 1'b1, BASE + 32'd8, 4'h0,    32'hFFFF_FFFF, 1'b0, "be0 wr");
    xfer(0, 1'b1, 1'b0, BASE + 32'd8, 4'hF,    32'h0,         1'b0, "be0 rd");

    // Back-to-back: request held across consecutive single-cycle accesses.
    xfer(0, 1'b0, 1'b1, BASE + 32'd12, 4'hF, 32'hA1A1_0001, 1'b1, "b2b wr0");
    xfer(0, 1'b0, 1'b1, BASE + 32'd16, 4'hF, 32'hB2B2_0002, 1'b1, "b2b wr1");
    xfer(0, 1'b1, 1'b0, BASE + 32'd12, 4'hF, 32'h0,         1'b1, "b2b rd0");
    xfer(0, 1'b1, 1'b0, BASE + 32'd16, 4'hF, 32'h0,         1'b0, "b2b rd1");

    // Range boundaries and sticky error.
    xfer(0, 1'b0, 1'b1, BASE + 32'd4092, 4'hF, 32'h600D_CAFE, 1'b0, "top word wr");
    xfer(0, 1'b1, 1'b0, BASE + 32'd4092, 4'hF, 32'h0,         1'b0, "top word rd");
    xfer(0, 1'b1, 1'b0, BASE - 32'd4,    4'hF, 32'h0,         1'b0, "t4 below");
    xfer(0, 1'b1, 1'b0, BASE + 32'd4096, 4'hF, 32'h0,         1'b0, "t4 above");
    xfer(0, 1'b0, 1'b1, BASE + 32'd4096, 4'hF, 32'h0BAD_0BAD, 1'b0, "t4 oob wr");
    xfer(0, 1'b1, 1'b0, BASE,            4'hF, 32'h0,         1'b0, "t4 no wrap");

    // Fixed two wait states, abandoned requests, read+write collision.
    xfer(1, 1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'h0BAD_F00D, 1'b0, "t2 wr");
    xfer(1, 1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'h0,         1'b0, "t2 rd");
    m_sel = 2'd1; m_addr = BASE + 32'd4; m_read = 1'b1;
    @(negedge clk); check("drop rd stall", 32'(w_wait), 32'd1);
    @(posedge clk); #1 m_read = 1'b0;
    @(negedge clk); check("drop rd idle", 32'(w_wait), 32'd0);
    @(posedge clk); #1;
    m_write = 1'b1; m_wdata = 32'h1234_5678; m_be = 4'hF;
    @(negedge clk); check("drop wr stall0", 32'(w_wait), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check("drop wr stall1", 32'(w_wait), 32'd1);
    @(posedge clk); #1 m_write = 1'b0;
    @(negedge clk);
    check("drop wr idle", 32'(w_wait), 32'd0);
    check("drop wr rdata", w_rdata, 32'h0);
    @(posedge clk); #1;
    xfer(1, 1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'h0,         1'b0, "drop rd back");
    xfer(1, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'hFFFF_0000, 1'b0, "rdwr both");
    xfer(1, 1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'h0,         1'b0, "rdwr no write");

    // Pseudo-random stalls from the LFSR.
    for (int i = 0; i < 16; i++)
      xfer(3, 1'b0, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom, 1'($urandom_range(0, 1)),
           $sformatf("t6 wr %0d", i));
    for (int i = 0; i < 200; i++)
      xfer(3, 1'b1, 1'b0, BASE + 32'(4 * $urandom_range(0, 15)), 4'hF, 32'h0,
           1'($urandom_range(0, 1)), $sformatf("t6 rd %0d", i));
    m_read = 1'b0; m_write = 1'b0;

    // Reset in the second WAIT cycle of a three-wait-state write.
    xfer(2, 1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'hCAFE_0001, 1'b0, "t5 pre");
    check("err vector before reset", 32'(w_err), 32'(err_vec()));
    m_sel = 2'd2; m_addr = BASE + 32'd8; m_write = 1'b1; m_be = 4'hF; m_wdata = 32'h5555_5555;
    @(negedge clk); check("t5 idle stall", 32'(w_wait), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check("t5 wait1 stall", 32'(w_wait), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    #1;
    check("t5 waitrequest in reset", 32'(w_wait), 32'd0);
    check("t5 readdata in reset", w_rdata, 32'h0);
    check("t5 error cleared", 32'(w_err), 32'h0);
    for (int i = 0; i < 4; i++) exp_err[i] = 1'b0;
    lfsr_m = 8'hA5;
    repeat (2) @(posedge clk);
    #1 m_write = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, 1'b0, "t5 word kept");
    xfer(0, 1'b1, 1'b0, BASE,         4'hF, 32'h0, 1'b0, "mem survives reset");
    for (int i = 0; i < 4; i++)
      xfer(3, 1'b1, 1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, 1'b0, $sformatf("reseed rd %0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
